// File: rtl/credit_rx_fifo.sv
// credit_rx_fifo: credit-link receive FIFO with FWFT output and one credit pulse per pop; define CREDIT_RX_FIFO_OVF_CHECK_EN for sticky overflow flag o_err
module credit_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_fifo_inc_sgnl,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [CW-1:0]     o_cnt
`ifdef CREDIT_RX_FIFO_OVF_CHECK_EN
  ,
  output logic              o_err
`endif
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic push, pop;
  // handshake decode; a full buffer still accepts a word when the head leaves in the same cycle
  always_comb begin
    o_vld  = cnt != '0;
    o_data = mem[rd_ptr];
    pop    = o_vld && i_ready;
    push   = i_vld && (cnt < CW'(DEPTH) || pop);
  end
  // payload storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end
  // pointers, occupancy and registered credit return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      o_fifo_inc_sgnl <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      cnt             <= push && !pop ? cnt + 1'b1 : pop && !push ? cnt - 1'b1 : cnt;
      o_fifo_inc_sgnl <= pop;
    end
  end
  assign o_cnt = cnt;
`ifdef CREDIT_RX_FIFO_OVF_CHECK_EN
  // sticky flag for a word arriving with no free entry and no pop to make room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_err <= 1'b0;
    else if (i_vld && !push) o_err <= 1'b1;
  end
`endif
endmodule
